wb_write_queue: RTL

- Writeback-side producer for the 32x32 register file. Owns the file's single write port (write enable, write address, write data).
- Accepts results from two producers: the single-cycle ALU path and the variable-latency memory/multiply path. Buffers them in a small in-order queue and drains exactly one entry per cycle into the register file.
- Provides two forwarding lookup ports, so decode reads see values that are still queued and not yet written.

---
 rtl/wb_write_queue.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
//
// Writeback-side producer for the register file. Results from the
// single-cycle ALU path and the variable-latency memory/multiply path are
// buffered in a small in-order circular queue. The queue drains one entry per
// cycle through the register file's single write port. Two forwarding lookup
// ports let decode see values that are still queued and not yet written.
//
// Ports:
//   clock, reset                     clock, synchronous active-high reset
//   mem_valid_in/addr_in/data_in     memory/multiply result (older when both push)
//   mem_ready_out                    queue can take a memory result this cycle
//   alu_valid_in/addr_in/data_in     ALU result
//   alu_ready_out                    queue can take an ALU result this cycle
//   we_out/waddr_out/wdata_out       register-file write port (head entry)
//   lookupN_addr_in                  forwarding lookup address (N = 1, 2)
//   lookupN_hit_out/data_out         hit flag and youngest matching data
//   count_out/empty_out/full_out     occupancy status
// ---------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    mem_valid_in,
    input  logic [ADDR_W-1:0]       mem_addr_in,
    input  logic [DATA_W-1:0]       mem_data_in,
    output logic                    mem_ready_out,

    input  logic                    alu_valid_in,
    input  logic [ADDR_W-1:0]       alu_addr_in,
    input  logic [DATA_W-1:0]       alu_data_in,
    output logic                    alu_ready_out,

    output logic                    we_out,
    output logic [ADDR_W-1:0]       waddr_out,
    output logic [DATA_W-1:0]       wdata_out,

    input  logic [ADDR_W-1:0]       lookup1_addr_in,
    output logic                    lookup1_hit_out,
    output logic [DATA_W-1:0]       lookup1_data_out,

    input  logic [ADDR_W-1:0]       lookup2_addr_in,
    output logic                    lookup2_hit_out,
    output logic [DATA_W-1:0]       lookup2_data_out,

    output logic [$clog2(DEPTH):0]  count_out,
    output logic                    empty_out,
    output logic                    full_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue state
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Handshake / control
    logic [CNT_W-1:0]  free;
    logic              mem_push;
    logic              alu_push;
    logic              pop;
    logic [PTR_W-1:0]  mem_slot;
    logic [PTR_W-1:0]  alu_slot;
    logic [PTR_W-1:0]  scan_idx;

    // Ready looks only at the registered count: a pop in this cycle frees its
    // slot for the next cycle, never the current one.
    assign free          = CNT_W'(DEPTH) - count_q;
    assign mem_ready_out = (free != '0);
    // With one slot left the memory path has priority for it.
    assign alu_ready_out = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_valid_in);

    // Writes to register 0 complete the handshake but are dropped here.
    assign mem_push = mem_valid_in && mem_ready_out && (mem_addr_in != '0);
    assign alu_push = alu_valid_in && alu_ready_out && (alu_addr_in != '0);
    assign pop      = (count_q != '0);

    // Memory entry is the older one when both push in the same cycle.
    assign mem_slot = tail_q;
    assign alu_slot = tail_q + PTR_W'(mem_push);

    // NOTE: every signal written in an always_comb block gets a default first
    // so that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(mem_push) + PTR_W'(alu_push);
        count_d = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
        valid_d = valid_q;
        // Pushes never target the head slot while it is occupied, so the
        // order of clear and set below cannot collide.
        if (pop)      valid_d[head_q]   = 1'b0;
        if (mem_push) valid_d[mem_slot] = 1'b1;
        if (alu_push) valid_d[alu_slot] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload arrays are deliberately not reset; nothing reads an
    // entry unless its valid bit (or the count) says it is live.
    always_ff @(posedge clock) begin
        if (mem_push) begin
            addr_q[mem_slot] <= mem_addr_in;
            data_q[mem_slot] <= mem_data_in;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= alu_addr_in;
            data_q[alu_slot] <= alu_data_in;
        end
    end

    // Drain: the head entry is presented every cycle the queue is non-empty.
    assign we_out    = pop;
    assign waddr_out = pop ? addr_q[head_q] : '0;
    assign wdata_out = pop ? data_q[head_q] : '0;

    // Forwarding: walk entries oldest to youngest from the head so that the
    // last match seen is the youngest one. The head entry being written this
    // cycle is still visible.
    always_comb begin
        lookup1_hit_out  = 1'b0;
        lookup1_data_out = '0;
        lookup2_hit_out  = 1'b0;
        lookup2_data_out = '0;
        scan_idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx]) begin
                if ((lookup1_addr_in != '0) && (addr_q[scan_idx] == lookup1_addr_in)) begin
                    lookup1_hit_out  = 1'b1;
                    lookup1_data_out = data_q[scan_idx];
                end
                if ((lookup2_addr_in != '0) && (addr_q[scan_idx] == lookup2_addr_in)) begin
                    lookup2_hit_out  = 1'b1;
                    lookup2_data_out = data_q[scan_idx];
                end
            end
        end
    end

    assign count_out = count_q;
    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == CNT_W'(DEPTH));

endmodule
